// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: parity codes, FSM states, parity check.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ARM = 2'd1,
        ST_RUN = 2'd2
    } rx_state_e;

    // A frame has a parity error when its 9 received bits do not have the configured parity.
    function automatic logic calc_perr(input int parity, input logic [8:0] frame);
        logic perr;
        perr = 1'b0;
        if (parity == PARITY_ODD) begin
            perr = ~^frame;
        end else if (parity == PARITY_EVEN) begin
            perr = ^frame;
        end
        return perr;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received {perr, byte} entries; the head is read straight from storage flops.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle; flush discards everything.
    always_comb begin
        rd_en    = pop & ~empty;
        wr_en    = push & (~full | rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // Storage, pointers and occupancy register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequences receiver_fsm: oversample tick, idle-line arming, frame edge capture, parity check and byte queue.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int PARITY     = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             rx,
    input  logic [8:0]       rx_data,
    input  logic             rx_done,
    output logic             rx_rst,
    output logic             sam_tick,
    output logic [7:0]       m_data,
    output logic             m_perr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             err_ovf,
    output logic             err_par,
    input  logic             err_clr
);

    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       idle_q, idle_d;
    logic             done_q, done_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_par_q, err_par_d;

    logic             active;
    logic             frame_edge;
    logic             perr;
    logic [7:0]       data_byte;
    logic             flush;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       fifo_rdata;

    assign active = (state_q != ST_OFF);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: dropping cfg_en always returns to OFF; ARM waits for 16 consecutive high ticks.
    always_comb begin
        state_d = state_q;
        if (!cfg_en) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:  state_d = ST_ARM;
                ST_ARM:  if (sam_tick && rx && (idle_q == 4'hF)) state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Outputs decoded from state: receiver runs only in RUN, tick only outside OFF.
    always_comb begin
        rx_rst   = (state_q != ST_RUN);
        sam_tick = active && (tick_cnt_q == div_q);
    end

    // Tick counter; the divisor is latched at each wrap so a new cfg_div applies from the next period.
    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        div_d      = div_q;
        if (!active || sam_tick) begin
            tick_cnt_d = '0;
            div_d      = cfg_div;
        end
    end

    // Idle-line counter: counts high ticks while arming, restarts whenever the line is low.
    always_comb begin
        idle_d = '0;
        if (state_q == ST_ARM) begin
            if (!rx) begin
                idle_d = '0;
            end else if (sam_tick) begin
                idle_d = idle_q + 1'b1;
            end else begin
                idle_d = idle_q;
            end
        end
    end

    // Frame capture: only a rising edge of rx_done in RUN produces a push.
    always_comb begin
        done_d     = rx_done;
        frame_edge = rx_done && !done_q && (state_q == ST_RUN);
        perr       = calc_perr(PARITY, rx_data);
        data_byte  = (PARITY != PARITY_NONE) ? rx_data[7:0] : rx_data[8:1];
        flush      = (state_d == ST_OFF);
        pop        = m_valid && m_ready;
    end

    // Sticky errors: a new error in the same cycle as err_clr is kept.
    always_comb begin
        err_ovf_d = err_ovf_q;
        err_par_d = err_par_q;
        if (err_clr) begin
            err_ovf_d = 1'b0;
            err_par_d = 1'b0;
        end
        if (frame_edge && !flush && fifo_full && !pop) begin
            err_ovf_d = 1'b1;
        end
        if (frame_edge && !flush && (!fifo_full || pop) && perr) begin
            err_par_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            div_q      <= '0;
            idle_q     <= '0;
            done_q     <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_par_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            div_q      <= div_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            err_ovf_q  <= err_ovf_d;
            err_par_q  <= err_par_d;
        end
    end

    uart_rx_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (frame_edge),
        .wdata   ({perr, data_byte}),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_rdata[7:0];
    assign m_perr  = fifo_rdata[8];
    assign err_ovf = err_ovf_q;
    assign err_par = err_par_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with PARITY=odd, FIFO_DEPTH=8.
module tb_uart_rx_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic        rx;
    logic [8:0]  rx_data;
    logic        rx_done;
    logic        rx_rst;
    logic        sam_tick;
    logic [7:0]  m_data;
    logic        m_perr;
    logic        m_valid;
    logic        m_ready;
    logic        err_ovf;
    logic        err_par;
    logic        err_clr;

    int checks;
    int errors;

    typedef struct {
        logic [8:0] din;
        logic [7:0] expByte;
        logic       expPerr;
    } frame_vec_t;

    frame_vec_t vecs [8];

    uart_rx_ctrl #(
        .PARITY     (1),
        .FIFO_DEPTH (8),
        .DIV_W      (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cfg_en   (cfg_en),
        .cfg_div  (cfg_div),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_rst   (rx_rst),
        .sam_tick (sam_tick),
        .m_data   (m_data),
        .m_perr   (m_perr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .err_ovf  (err_ovf),
        .err_par  (err_par),
        .err_clr  (err_clr)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic line, input logic [8:0] data,
                                 input logic done, input logic ready, input logic clr);
        cfg_en  = en;
        rx      = line;
        rx_data = data;
        rx_done = done;
        m_ready = ready;
        err_clr = clr;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Odd-parity bit that makes the 9-bit frame error free.
    function automatic logic [8:0] goodFrame(input logic [7:0] b);
        return {~(^b), b};
    endfunction

    initial begin
        int cycles;
        int ticks;
        int after;
        int lastTick;
        int period;
        bit lowDone;
        bit expPar;
        logic [7:0] drainExp [8];

        checks = 0;
        errors = 0;

        vecs[0] = '{din: 9'h155, expByte: 8'h55, expPerr: 1'b0};
        vecs[1] = '{din: 9'h055, expByte: 8'h55, expPerr: 1'b1};
        vecs[2] = '{din: 9'h1FF, expByte: 8'hFF, expPerr: 1'b0};
        vecs[3] = '{din: 9'h000, expByte: 8'h00, expPerr: 1'b1};
        vecs[4] = '{din: 9'h0A1, expByte: 8'hA1, expPerr: 1'b0};
        vecs[5] = '{din: 9'h13C, expByte: 8'h3C, expPerr: 1'b0};
        vecs[6] = '{din: 9'h080, expByte: 8'h80, expPerr: 1'b0};
        vecs[7] = '{din: 9'h003, expByte: 8'h03, expPerr: 1'b1};

        // Reset values.
        reset_n = 1'b0;
        cfg_div = 16'd3;
        applyStimulus(1'b0, 1'b1, 9'h0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("reset_rx_rst", rx_rst, 1);
        checkOutput("reset_sam_tick", sam_tick, 0);
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_data", m_data, 0);
        checkOutput("reset_m_perr", m_perr, 0);
        checkOutput("reset_err_ovf", err_ovf, 0);
        checkOutput("reset_err_par", err_par, 0);
        reset_n = 1'b1;
        step();

        // Arming with a steady idle line: tick every 4 clks, RUN after 16 ticks.
        applyStimulus(1'b1, 1'b1, 9'h0, 1'b0, 1'b0, 1'b0);
        cycles   = 0;
        ticks    = 0;
        lastTick = -1;
        period   = 0;
        while (cycles < 200) begin
            step();
            cycles++;
            if (rx_rst == 1'b0) break;
            if (sam_tick) begin
                ticks++;
                if (lastTick >= 0) period = cycles - lastTick;
                lastTick = cycles;
            end
        end
        checkOutput("arm_cycles", cycles, 65);
        checkOutput("arm_ticks", ticks, 16);
        checkOutput("tick_period", period, 4);
        checkOutput("run_rx_rst", rx_rst, 0);

        // Line low at the 10th tick restarts the idle count.
        applyStimulus(1'b0, 1'b1, 9'h0, 1'b0, 1'b0, 1'b0);
        step();
        cfg_en  = 1'b1;
        ticks   = 0;
        after   = 0;
        lowDone = 1'b0;
        for (int i = 0; i < 300 && rx_rst; i++) begin
            step();
            if (sam_tick && rx_rst) begin
                ticks++;
                if (lowDone) after++;
                if (ticks == 10 && !lowDone) begin
                    rx = 1'b0;
                    step();
                    rx      = 1'b1;
                    lowDone = 1'b1;
                end
            end
        end
        checkOutput("rearm_ticks_after_low", after, 16);
        checkOutput("rearm_rx_rst", rx_rst, 0);

        // Table of frames, rx_done held 3 clks each, popped one at a time.
        expPar = 1'b0;
        for (int v = 0; v < 8; v++) begin
            applyStimulus(1'b1, 1'b1, vecs[v].din, 1'b1, 1'b0, 1'b0);
            step();
            expPar = expPar | vecs[v].expPerr;
            checkOutput($sformatf("vec%0d_valid", v), m_valid, 1);
            checkOutput($sformatf("vec%0d_data", v), m_data, vecs[v].expByte);
            checkOutput($sformatf("vec%0d_perr", v), m_perr, vecs[v].expPerr);
            checkOutput($sformatf("vec%0d_err_par", v), err_par, expPar);
            step();
            step();
            applyStimulus(1'b1, 1'b1, vecs[v].din, 1'b0, 1'b1, 1'b0);
            step();
            m_ready = 1'b0;
            checkOutput($sformatf("vec%0d_single_push", v), m_valid, 0);
        end

        // err_clr clears the sticky parity flag.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checkOutput("err_par_clr", err_par, 0);

        // Overflow: 9 frames with no pops.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 1'b1, goodFrame(8'h10 + 8'(i)), 1'b1, 1'b0, 1'b0);
            step();
            rx_done = 1'b0;
            step();
        end
        checkOutput("ovf_m_valid", m_valid, 1);
        checkOutput("ovf_err_ovf", err_ovf, 1);
        checkOutput("ovf_err_par", err_par, 0);
        checkOutput("ovf_head", m_data, 8'h10);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checkOutput("ovf_clr", err_ovf, 0);

        // Push into a full FIFO while popping: no overflow, new byte at the tail.
        applyStimulus(1'b1, 1'b1, goodFrame(8'h30), 1'b1, 1'b1, 1'b0);
        step();
        applyStimulus(1'b1, 1'b1, goodFrame(8'h30), 1'b0, 1'b0, 1'b0);
        checkOutput("full_pushpop_ovf", err_ovf, 0);
        for (int i = 0; i < 7; i++) drainExp[i] = 8'h11 + 8'(i);
        drainExp[7] = 8'h30;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("drain%0d_valid", i), m_valid, 1);
            checkOutput($sformatf("drain%0d_data", i), m_data, drainExp[i]);
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
        end
        checkOutput("drain_empty", m_valid, 0);

        // Dropping cfg_en flushes queued bytes but keeps error flags.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, (i == 0) ? 9'h055 : goodFrame(8'h40 + 8'(i)), 1'b1, 1'b0, 1'b0);
            step();
            rx_done = 1'b0;
            step();
        end
        checkOutput("pre_off_valid", m_valid, 1);
        checkOutput("pre_off_err_par", err_par, 1);
        cfg_en = 1'b0;
        step();
        checkOutput("off_m_valid", m_valid, 0);
        checkOutput("off_rx_rst", rx_rst, 1);
        checkOutput("off_sam_tick", sam_tick, 0);
        checkOutput("off_err_par", err_par, 1);
        checkOutput("off_err_ovf", err_ovf, 0);

        // rx_done edges in OFF and ARM are ignored.
        rx_data = goodFrame(8'h77);
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        step();
        checkOutput("off_done_ignored", m_valid, 0);
        cfg_en = 1'b1;
        step();
        step();
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        step();
        checkOutput("arm_state_rx_rst", rx_rst, 1);
        checkOutput("arm_done_ignored", m_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
